// File: rtl/mac_seq_pkg.sv
// Shared types and constants for the MAC sequencer: state encoding,
// default widths, header size limit and saturation bounds.
package mac_seq_pkg;

  localparam int DEF_ADDR_WIDTH = 12;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int ACC_WIDTH      = 40;

  // Largest M*N accepted; weights occupy addresses 1..M*N in a 4K SRAM.
  localparam logic [15:0] HDR_LIMIT = 16'd4094;

  localparam logic signed [15:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [15:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    IDLE,
    HDR_REQ,
    HDR_WAIT,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/mac_sat_acc.sv
// Signed multiply-accumulate datapath: full-width product, 40-bit
// accumulator with clear/enable, and a saturating output.
module mac_sat_acc
  import mac_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] sat
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] acc_d;
  logic signed [ACC_WIDTH-1:0] acc_q;

  always_comb begin
    prod = $signed({{DATA_WIDTH{a[DATA_WIDTH-1]}}, a})
         * $signed({{DATA_WIDTH{b[DATA_WIDTH-1]}}, b});

    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end
    if (en) begin
      acc_d = acc_d + ACC_WIDTH'(prod);
    end

    if (acc_q > ACC_WIDTH'(SAT_MAX)) begin
      sat = DATA_WIDTH'(SAT_MAX);
    end else if (acc_q < ACC_WIDTH'(SAT_MIN)) begin
      sat = DATA_WIDTH'(SAT_MIN);
    end else begin
      sat = acc_q[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/mac_sequencer.sv
// Matrix-vector sequencer: reads an N/M header, streams input and weight
// SRAMs through a MAC and writes one saturated result per output row.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  dut_run,
  output logic                  dut_busy,
  output logic [ADDR_WIDTH-1:0] dut_sram_read_address,
  input  logic [DATA_WIDTH-1:0] sram_dut_read_data,
  output logic [ADDR_WIDTH-1:0] dut_wmem_read_address,
  input  logic [DATA_WIDTH-1:0] wmem_dut_read_data,
  output logic                  dut_sram_write_enable,
  output logic [ADDR_WIDTH-1:0] dut_sram_write_address,
  output logic [DATA_WIDTH-1:0] dut_sram_write_data
);

  state_e                state_d, state_q;
  logic [7:0]            n_d, n_q;
  logic [7:0]            m_d, m_q;
  logic [7:0]            col_d, col_q;
  logic [7:0]            row_d, row_q;
  logic [ADDR_WIDTH-1:0] wbase_d, wbase_q;
  logic                  pv_d, pv_q;

  logic                  acc_clr;
  logic [DATA_WIDTH-1:0] sat_out;
  logic [15:0]           hdr_size;

  mac_sat_acc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_acc (
    .clk    (clk),
    .reset_b(reset_b),
    .clr    (acc_clr),
    .en     (pv_q),
    .a      (sram_dut_read_data),
    .b      (wmem_dut_read_data),
    .sat    (sat_out)
  );

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    m_d      = m_q;
    col_d    = col_q;
    row_d    = row_q;
    wbase_d  = wbase_q;
    pv_d     = 1'b0;
    acc_clr  = 1'b0;
    hdr_size = '0;

    dut_busy               = 1'b1;
    dut_sram_read_address  = '0;
    dut_wmem_read_address  = '0;
    dut_sram_write_enable  = 1'b0;
    dut_sram_write_address = '0;
    dut_sram_write_data    = '0;

    unique case (state_q)
      IDLE: begin
        dut_busy = 1'b0;
        if (dut_run) begin
          state_d = HDR_REQ;
        end
      end
      HDR_REQ: begin
        state_d = HDR_WAIT;
      end
      HDR_WAIT: begin
        n_d      = sram_dut_read_data[7:0];
        m_d      = wmem_dut_read_data[7:0];
        col_d    = '0;
        row_d    = '0;
        wbase_d  = '0;
        hdr_size = {8'd0, n_d} * {8'd0, m_d};
        if (n_d == '0 || m_d == '0 || hdr_size > HDR_LIMIT) begin
          state_d = DONE;
        end else begin
          state_d = MAC;
        end
      end
      MAC: begin
        // wbase_q tracks r*N so no multiplier is needed on the address path.
        dut_sram_read_address = ADDR_WIDTH'(1) + ADDR_WIDTH'(col_q);
        dut_wmem_read_address = ADDR_WIDTH'(1) + wbase_q + ADDR_WIDTH'(col_q);
        pv_d    = 1'b1;
        acc_clr = (col_q == '0);
        if (col_q == n_q - 8'd1) begin
          col_d   = '0;
          state_d = DRAIN;
        end else begin
          col_d = col_q + 8'd1;
        end
      end
      DRAIN: begin
        state_d = WRITE;
      end
      WRITE: begin
        dut_sram_write_enable  = 1'b1;
        dut_sram_write_address = ADDR_WIDTH'(row_q);
        dut_sram_write_data    = sat_out;
        if (row_q == m_q - 8'd1) begin
          state_d = DONE;
        end else begin
          row_d   = row_q + 8'd1;
          wbase_d = wbase_q + ADDR_WIDTH'(n_q);
          state_d = MAC;
        end
      end
      DONE: begin
        dut_busy = 1'b0;
        if (!dut_run) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      n_q     <= '0;
      m_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wbase_q <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      m_q     <= m_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wbase_q <= wbase_d;
      pv_q    <= pv_d;
    end
  end

endmodule

// File: tb/tb_mac_sequencer.sv
// Scoreboard bench for mac_sequencer: SRAM models, a reference model of the
// matrix-vector result, and a monitor checking writes and busy duration.
module tb_mac_sequencer;

  localparam int AW = 12;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          dut_run = 1'b0;
  logic          dut_busy;
  logic [AW-1:0] dut_sram_read_address;
  logic [DW-1:0] sram_dut_read_data;
  logic [AW-1:0] dut_wmem_read_address;
  logic [DW-1:0] wmem_dut_read_data;
  logic          dut_sram_write_enable;
  logic [AW-1:0] dut_sram_write_address;
  logic [DW-1:0] dut_sram_write_data;

  always #5 clk = ~clk;

  mac_sequencer #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk                   (clk),
    .reset_b               (reset_b),
    .dut_run               (dut_run),
    .dut_busy              (dut_busy),
    .dut_sram_read_address (dut_sram_read_address),
    .sram_dut_read_data    (sram_dut_read_data),
    .dut_wmem_read_address (dut_wmem_read_address),
    .wmem_dut_read_data    (wmem_dut_read_data),
    .dut_sram_write_enable (dut_sram_write_enable),
    .dut_sram_write_address(dut_sram_write_address),
    .dut_sram_write_data   (dut_sram_write_data)
  );

  logic [15:0] in_mem [0:4095];
  logic [15:0] w_mem  [0:4095];

  always @(posedge clk) begin
    sram_dut_read_data <= in_mem[dut_sram_read_address];
    wmem_dut_read_data <= w_mem[dut_wmem_read_address];
  end

  typedef struct packed {
    logic [11:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t  wq[$];
  int   busy_q[$];
  int   checks = 0;
  int   failures = 0;
  int   busy_cnt = 0;
  int   jobs_started = 0;
  logic busy_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input longint s);
    if (s > 32767) return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return 16'(s);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT writes or ends a job.
  always @(negedge clk) begin
    wr_t e;
    if (reset_b) begin
      if (dut_sram_write_enable) begin
        if (wq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr=%0d data=0x%h expected no write",
                   dut_sram_write_address, dut_sram_write_data);
        end else begin
          e = wq.pop_front();
          check("wr_addr", 64'(dut_sram_write_address), 64'(e.addr));
          check("wr_data", 64'(dut_sram_write_data), 64'(e.data));
        end
      end else begin
        check("wr_idle", 64'({dut_sram_write_address, dut_sram_write_data}), 64'd0);
      end
      if (!dut_busy) begin
        check("rd_idle", 64'({dut_sram_read_address, dut_wmem_read_address}), 64'd0);
      end
      if (dut_busy) begin
        if (!busy_prev) jobs_started++;
        busy_cnt++;
      end else if (busy_cnt > 0) begin
        if (busy_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_job: got busy=%0d cycles expected no job", busy_cnt);
        end else begin
          check("busy_len", 64'(busy_cnt), 64'(busy_q.pop_front()));
        end
        busy_cnt = 0;
      end
      busy_prev = dut_busy;
    end
  end

  function automatic logic [15:0] gen(input int mode);
    case (mode)
      0:       return 16'($urandom);
      1:       return 16'($urandom_range(20) - 10);
      default: return ($urandom_range(1) == 1) ? 16'h7FFF : 16'h8000;
    endcase
  endfunction

  task automatic set_header(input int n, input int m);
    in_mem[0] = {8'($urandom), 8'(n)};
    w_mem[0]  = {8'($urandom), 8'(m)};
  endtask

  task automatic load_random(input int n, input int m, input int mode);
    set_header(n, m);
    for (int c = 1; c <= n; c++) in_mem[c] = gen(mode);
    for (int i = 1; i <= n * m && i < 4096; i++) w_mem[i] = gen(mode);
  endtask

  // Reference: out[r] = sat16(sum_c in[1+c] * w[1+r*N+c]) from the memory images.
  task automatic expect_job();
    int     n, m;
    longint s;
    wr_t    e;
    n = int'(in_mem[0][7:0]);
    m = int'(w_mem[0][7:0]);
    if (n == 0 || m == 0 || n * m > 4094) begin
      busy_q.push_back(2);
    end else begin
      for (int r = 0; r < m; r++) begin
        s = 0;
        for (int c = 0; c < n; c++) begin
          s += longint'($signed(in_mem[1 + c])) * longint'($signed(w_mem[1 + r * n + c]));
        end
        e.addr = 12'(r);
        e.data = sat16(s);
        wq.push_back(e);
      end
      busy_q.push_back(2 + m * (n + 2));
    end
  endtask

  task automatic pulse_run();
    @(negedge clk);
    dut_run = 1'b1;
    @(negedge clk);
    dut_run = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (dut_busy && k < 20000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20000) check("done_timeout", 64'(dut_busy), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_job();
    expect_job();
    pulse_run();
    wait_done();
  endtask

  task automatic load_req037();
    set_header(3, 2);
    in_mem[1] = 16'd1; in_mem[2] = 16'hFFFF; in_mem[3] = 16'd2;
    for (int i = 1; i <= 6; i++) w_mem[i] = 16'(i);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    for (int i = 0; i < 4096; i++) begin
      in_mem[i] = '0;
      w_mem[i]  = '0;
    end

    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({dut_busy, dut_sram_write_enable, dut_sram_read_address,
          dut_wmem_read_address, dut_sram_write_address, dut_sram_write_data}), 64'd0);
    reset_b = 1'b1;
    repeat (2) @(negedge clk);

    // N=2, M=1 -> 39, busy 6
    set_header(2, 1);
    in_mem[1] = 16'd3; in_mem[2] = 16'd4; w_mem[1] = 16'd5; w_mem[2] = 16'd6;
    do_job();

    load_req037();
    do_job();

    // Saturation both ways
    set_header(2, 1);
    in_mem[1] = 16'h7FFF; in_mem[2] = 16'h7FFF; w_mem[1] = 16'h7FFF; w_mem[2] = 16'h7FFF;
    do_job();
    in_mem[1] = 16'h8000; in_mem[2] = 16'h8000;
    do_job();

    // Rejected headers: N=0, M=0, M*N=4095; then the largest accepted size
    load_random(0, 3, 0);  do_job();
    load_random(4, 0, 0);  do_job();
    load_random(63, 65, 0); do_job();
    load_random(46, 89, 0); do_job();

    // Asynchronous reset during row 1
    load_req037();
    expect_job();
    pulse_run();
    repeat (7) @(negedge clk);
    #1 reset_b = 1'b0;
    #1 check("async_reset", 64'({dut_busy, dut_sram_write_enable, dut_sram_read_address,
             dut_wmem_read_address, dut_sram_write_address, dut_sram_write_data}), 64'd0);
    wq.delete();
    busy_q.delete();
    busy_cnt  = 0;
    busy_prev = 1'b0;
    repeat (2) @(negedge clk);
    reset_b = 1'b1;
    @(negedge clk);
    do_job();

    // dut_run held high yields one job; another needs a low-high sequence
    load_random(2, 2, 1);
    expect_job();
    start = jobs_started;
    @(negedge clk);
    dut_run = 1'b1;
    repeat (100) @(negedge clk);
    check("held_run_jobs", 64'(jobs_started - start), 64'd1);
    check("held_run_idle", 64'(dut_busy), 64'd0);
    dut_run = 1'b0;
    repeat (2) @(negedge clk);
    start = jobs_started;
    load_random(3, 2, 1);
    do_job();
    check("rerun_jobs", 64'(jobs_started - start), 64'd1);

    for (int j = 0; j < 10; j++) begin
      load_random($urandom_range(1, 12), $urandom_range(1, 6), j % 3);
      do_job();
    end

    check("wq_empty", 64'(wq.size()), 64'd0);
    check("busyq_empty", 64'(busy_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
